// File: rtl/rename_reg_file_pkg.sv
// Shared constants for the rename register file.
// Register count, null tag and small helpers.
package rename_reg_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int NULL_TAG = 0;

  function automatic logic is_nz(input logic [4:0] r);
    return r != 5'd0;
  endfunction

endpackage

// File: rtl/rename_ckpt_ctrl.sv
// Checkpoint ring control: head/tail/count,
// take, release, recover-truncate and full.
module rename_ckpt_ctrl #(
  parameter int CKPT_WIDTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic                  take_i,
  input  logic                  rel_i,
  input  logic                  rec_i,
  input  logic [CKPT_WIDTH-1:0] rec_id_i,
  output logic [CKPT_WIDTH-1:0] ckpt_id_o,
  output logic                  full_o,
  output logic [CKPT_WIDTH:0]   count_o,
  output logic                  snap_we_o,
  output logic [CKPT_WIDTH-1:0] snap_idx_o
);

  localparam int N = 1 << CKPT_WIDTH;

  logic [CKPT_WIDTH-1:0] head_q, head_d;
  logic [CKPT_WIDTH-1:0] tail_q, tail_d;
  logic [CKPT_WIDTH:0]   cnt_q, cnt_d;
  logic                  take, rel;

  // Full is judged on the registered count,
  // so a same-cycle release cannot unblock a take.
  assign full_o     = cnt_q == (CKPT_WIDTH+1)'(N);
  assign take       = take_i && !full_o;
  assign rel        = rel_i && (cnt_q != '0);
  assign ckpt_id_o  = tail_q;
  assign count_o    = cnt_q;
  assign snap_idx_o = tail_q;
  assign snap_we_o  = !rst_in && rdy_in && !clr_in
                      && !rec_i && take;

  // Ring pointer next state by flush/recover/normal priority.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clr_in) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (rec_i) begin
      tail_d = rec_id_i;
      cnt_d  = {1'b0, CKPT_WIDTH'(rec_id_i - head_q)};
    end else begin
      tail_d = tail_q + CKPT_WIDTH'(take);
      head_d = head_q + CKPT_WIDTH'(rel);
      cnt_d  = cnt_q + (CKPT_WIDTH+1)'(take)
               - (CKPT_WIDTH+1)'(rel);
    end
  end

  // Ring state register with pause hold.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_in) begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags,
// commit bypass and branch checkpoints.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int ROB_WIDTH  = 4,
  parameter int XLEN       = 32,
  parameter int CKPT_WIDTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic                  issue_ready,
  input  logic [4:0]            issue_rd_id,
  input  logic [ROB_WIDTH-1:0]  issue_rob_idx,
  input  logic                  issue_ckpt,
  output logic [CKPT_WIDTH-1:0] ckpt_id,
  output logic                  ckpt_full,
  output logic [CKPT_WIDTH:0]   ckpt_count,
  input  logic                  ckpt_release,
  input  logic                  recover_valid,
  input  logic [CKPT_WIDTH-1:0] recover_ckpt_id,
  input  logic [4:0]            iu_to_rf_rs1_id,
  input  logic [4:0]            iu_to_rf_rs2_id,
  output logic [XLEN-1:0]       rf_to_iu_val1,
  output logic [XLEN-1:0]       rf_to_iu_val2,
  output logic [ROB_WIDTH-1:0]  rf_to_iu_rs1_depend,
  output logic [ROB_WIDTH-1:0]  rf_to_iu_rs2_depend,
  input  logic                  rob_to_rf_ready,
  input  logic [4:0]            rob_to_rf_reg_id,
  input  logic [XLEN-1:0]       rob_to_rf_reg_val,
  input  logic [ROB_WIDTH-1:0]  rob_to_rf_rob_idx
);

  localparam int N = 1 << CKPT_WIDTH;
  localparam logic [ROB_WIDTH-1:0] NT = ROB_WIDTH'(NULL_TAG);

  logic [XLEN-1:0]      val_q [NUM_REGS];
  logic [XLEN-1:0]      val_d [NUM_REGS];
  logic [ROB_WIDTH-1:0] dep_q [NUM_REGS];
  logic [ROB_WIDTH-1:0] dep_d [NUM_REGS];
  logic [ROB_WIDTH-1:0] snap_q [N][NUM_REGS];
  logic [ROB_WIDTH-1:0] snap_d [N][NUM_REGS];

  logic                  cm, iss, snap_we;
  logic [4:0]            crd;
  logic [CKPT_WIDTH-1:0] snap_idx;

  assign cm  = rob_to_rf_ready && is_nz(rob_to_rf_reg_id);
  assign iss = issue_ready && is_nz(issue_rd_id);
  assign crd = rob_to_rf_reg_id;

  rename_ckpt_ctrl #(
    .CKPT_WIDTH(CKPT_WIDTH)
  ) u_ctrl (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clr_in     (clr_in),
    .take_i     (issue_ckpt),
    .rel_i      (ckpt_release),
    .rec_i      (recover_valid),
    .rec_id_i   (recover_ckpt_id),
    .ckpt_id_o  (ckpt_id),
    .full_o     (ckpt_full),
    .count_o    (ckpt_count),
    .snap_we_o  (snap_we),
    .snap_idx_o (snap_idx)
  );

  // Read port 1 with x0 forcing and commit bypass.
  always_comb begin
    rf_to_iu_val1       = val_q[iu_to_rf_rs1_id];
    rf_to_iu_rs1_depend = dep_q[iu_to_rf_rs1_id];
    if (!is_nz(iu_to_rf_rs1_id)) begin
      rf_to_iu_val1       = '0;
      rf_to_iu_rs1_depend = NT;
    end else if (cm && crd == iu_to_rf_rs1_id
                 && rob_to_rf_rob_idx == dep_q[crd]) begin
      rf_to_iu_val1       = rob_to_rf_reg_val;
      rf_to_iu_rs1_depend = NT;
    end
  end

  // Read port 2 with x0 forcing and commit bypass.
  always_comb begin
    rf_to_iu_val2       = val_q[iu_to_rf_rs2_id];
    rf_to_iu_rs2_depend = dep_q[iu_to_rf_rs2_id];
    if (!is_nz(iu_to_rf_rs2_id)) begin
      rf_to_iu_val2       = '0;
      rf_to_iu_rs2_depend = NT;
    end else if (cm && crd == iu_to_rf_rs2_id
                 && rob_to_rf_rob_idx == dep_q[crd]) begin
      rf_to_iu_val2       = rob_to_rf_reg_val;
      rf_to_iu_rs2_depend = NT;
    end
  end

  // Table next state: flush, recover, or issue/commit/take.
  always_comb begin
    val_d  = val_q;
    dep_d  = dep_q;
    snap_d = snap_q;
    if (cm) val_d[crd] = rob_to_rf_reg_val;
    if (clr_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        dep_d[i] = NT;
        for (int k = 0; k < N; k++) snap_d[k][i] = NT;
      end
    end else begin
      if (cm) begin
        for (int k = 0; k < N; k++)
          if (snap_q[k][crd] == rob_to_rf_rob_idx)
            snap_d[k][crd] = NT;
      end
      if (recover_valid) begin
        dep_d = snap_q[recover_ckpt_id];
        if (cm && dep_d[crd] == rob_to_rf_rob_idx)
          dep_d[crd] = NT;
      end else begin
        if (cm && dep_q[crd] == rob_to_rf_rob_idx
            && !(iss && issue_rd_id == crd))
          dep_d[crd] = NT;
        if (iss) dep_d[issue_rd_id] = issue_rob_idx;
        if (snap_we) snap_d[snap_idx] = dep_d;
      end
    end
  end

  // Array registers with reset and pause hold.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        dep_q[i] <= NT;
        for (int k = 0; k < N; k++) snap_q[k][i] <= NT;
      end
    end else if (rdy_in) begin
      val_q  <= val_d;
      dep_q  <= dep_d;
      snap_q <= snap_d;
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Bench for rename_reg_file: directed plan steps
// then random traffic against a queue-based model.
module tb_rename_reg_file;

  localparam int RW = 4;
  localparam int XL = 32;
  localparam int CW = 2;
  localparam int N  = 4;

  typedef logic [31:0][RW-1:0] tbl_t;

  logic          clk_in = 0;
  logic          rst_in, rdy_in, clr_in;
  logic          issue_ready, issue_ckpt;
  logic [4:0]    issue_rd_id;
  logic [RW-1:0] issue_rob_idx;
  logic [CW-1:0] ckpt_id;
  logic          ckpt_full;
  logic [CW:0]   ckpt_count;
  logic          ckpt_release, recover_valid;
  logic [CW-1:0] recover_ckpt_id;
  logic [4:0]    rs1, rs2;
  logic [XL-1:0] val1, val2;
  logic [RW-1:0] dep1, dep2;
  logic          rob_ready;
  logic [4:0]    rob_reg;
  logic [XL-1:0] rob_val;
  logic [RW-1:0] rob_idx;

  int nerr = 0;
  int nchk = 0;

  logic [XL-1:0] m_val [32];
  tbl_t          m_dep;
  tbl_t          m_q [$];
  int            m_head;

  rename_reg_file #(
    .ROB_WIDTH(RW), .XLEN(XL), .CKPT_WIDTH(CW)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .issue_ready         (issue_ready),
    .issue_rd_id         (issue_rd_id),
    .issue_rob_idx       (issue_rob_idx),
    .issue_ckpt          (issue_ckpt),
    .ckpt_id             (ckpt_id),
    .ckpt_full           (ckpt_full),
    .ckpt_count          (ckpt_count),
    .ckpt_release        (ckpt_release),
    .recover_valid       (recover_valid),
    .recover_ckpt_id     (recover_ckpt_id),
    .iu_to_rf_rs1_id     (rs1),
    .iu_to_rf_rs2_id     (rs2),
    .rf_to_iu_val1       (val1),
    .rf_to_iu_val2       (val2),
    .rf_to_iu_rs1_depend (dep1),
    .rf_to_iu_rs2_depend (dep2),
    .rob_to_rf_ready     (rob_ready),
    .rob_to_rf_reg_id    (rob_reg),
    .rob_to_rf_reg_val   (rob_val),
    .rob_to_rf_rob_idx   (rob_idx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; clr_in = 0;
    issue_ready = 0; issue_rd_id = 0;
    issue_rob_idx = 0; issue_ckpt = 0;
    ckpt_release = 0; recover_valid = 0;
    recover_ckpt_id = 0;
    rob_ready = 0; rob_reg = 0; rob_val = 0; rob_idx = 0;
  endtask

  task automatic exp_read(input logic [4:0] a,
                          output logic [XL-1:0] v,
                          output logic [RW-1:0] t);
    if (a == 0) begin
      v = 0; t = 0;
    end else if (rob_ready && rob_reg == a
                 && rob_idx == m_dep[a]) begin
      v = rob_val; t = 0;
    end else begin
      v = m_val[a]; t = m_dep[a];
    end
  endtask

  task automatic model_edge();
    bit cm, iss, full_pre;
    int p;
    tbl_t t;
    if (rst_in) begin
      for (int i = 0; i < 32; i++) m_val[i] = 0;
      m_dep = '0; m_q.delete(); m_head = 0;
      return;
    end
    if (!rdy_in) return;
    cm = rob_ready && rob_reg != 0;
    if (cm) m_val[rob_reg] = rob_val;
    if (clr_in) begin
      m_dep = '0; m_q.delete(); m_head = 0;
      return;
    end
    if (cm)
      foreach (m_q[k])
        if (m_q[k][rob_reg] == rob_idx) m_q[k][rob_reg] = 0;
    if (recover_valid) begin
      p = (int'(recover_ckpt_id) - m_head + N) % N;
      assert (p < m_q.size())
        else $fatal(1, "FAIL illegal_recover id=%0d", p);
      t = m_q[p];
      while (m_q.size() > p) void'(m_q.pop_back());
      m_dep = t;
      return;
    end
    iss = issue_ready && issue_rd_id != 0;
    if (cm && m_dep[rob_reg] == rob_idx
        && !(iss && issue_rd_id == rob_reg))
      m_dep[rob_reg] = 0;
    if (iss) m_dep[issue_rd_id] = issue_rob_idx;
    full_pre = m_q.size() == N;
    if (ckpt_release && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % N;
    end
    if (issue_ckpt && !full_pre) m_q.push_back(m_dep);
  endtask

  task automatic step();
    logic [XL-1:0] ev;
    logic [RW-1:0] et;
    #1;
    if (!rst_in) begin
      exp_read(rs1, ev, et);
      chk("val1", val1, ev);
      chk("dep1", dep1, et);
      exp_read(rs2, ev, et);
      chk("val2", val2, ev);
      chk("dep2", dep2, et);
      chk("ckpt_id", ckpt_id, (m_head + m_q.size()) % N);
      chk("ckpt_full", ckpt_full, m_q.size() == N);
      chk("ckpt_count", ckpt_count, m_q.size());
    end
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  initial begin
    m_dep = '0; m_head = 0;
    for (int i = 0; i < 32; i++) m_val[i] = 0;
    idle(); rs1 = 0; rs2 = 0;
    @(negedge clk_in);
    rst_in = 1; step(); step(); rst_in = 0;

    rs1 = 5; #1;
    chk("reset_x5_val", val1, 0);
    chk("reset_x5_tag", dep1, 0);
    chk("reset_count", ckpt_count, 0);
    step();

    issue_ready = 1; issue_rd_id = 5; issue_rob_idx = 3;
    step(); idle(); #1;
    chk("issue_x5_tag", dep1, 3);
    step();

    rob_ready = 1; rob_reg = 5; rob_idx = 3;
    rob_val = 32'hDEADBEEF; #1;
    chk("bypass_val", val1, 32'hDEADBEEF);
    chk("bypass_tag", dep1, 0);
    step(); idle(); #1;
    chk("commit_val", val1, 32'hDEADBEEF);
    chk("commit_tag", dep1, 0);
    step();

    issue_ready = 1; issue_rd_id = 7; issue_rob_idx = 2;
    step(); idle();
    issue_ready = 1; issue_rd_id = 7; issue_rob_idx = 9;
    rob_ready = 1; rob_reg = 7; rob_idx = 2; rob_val = 32'h77;
    step(); idle(); rs1 = 7; #1;
    chk("collide_tag", dep1, 9);
    chk("collide_val", val1, 32'h77);
    step();

    issue_ready = 1; issue_rd_id = 1; issue_rob_idx = 4;
    issue_ckpt = 1; #1;
    chk("take_id0", ckpt_id, 0);
    step(); idle();
    issue_ready = 1; issue_rd_id = 1; issue_rob_idx = 6;
    step(); idle();
    recover_valid = 1; recover_ckpt_id = 0;
    step(); idle(); rs1 = 1; #1;
    chk("recover_tag", dep1, 4);
    chk("recover_count", ckpt_count, 0);
    step();

    for (int i = 0; i < 4; i++) begin
      issue_ckpt = 1; step();
    end
    idle(); #1;
    chk("full_after4", ckpt_full, 1);
    issue_ckpt = 1; step(); idle(); #1;
    chk("take_when_full", ckpt_count, 4);
    ckpt_release = 1; step(); idle(); #1;
    chk("release_count", ckpt_count, 3);
    chk("wrap_id", ckpt_id, 0);
    issue_ckpt = 1; step(); idle();
    issue_ckpt = 1; ckpt_release = 1; step(); idle(); #1;
    chk("take_rel_full", ckpt_count, 3);
    step();

    clr_in = 1; step(); idle();
    issue_ready = 1; issue_rd_id = 2; issue_rob_idx = 5;
    step(); idle();
    issue_ckpt = 1; step(); idle();
    rob_ready = 1; rob_reg = 2; rob_idx = 5; rob_val = 32'h22;
    step(); idle();
    recover_valid = 1; recover_ckpt_id = 0;
    step(); idle(); rs1 = 2; #1;
    chk("snap_commit_clr", dep1, 0);
    step();

    issue_ready = 1; issue_rd_id = 3; issue_rob_idx = 7;
    step(); idle();
    issue_ckpt = 1; step(); step(); idle();
    clr_in = 1; step(); idle();
    rs1 = 5; rs2 = 3; #1;
    chk("clr_val_kept", val1, 32'hDEADBEEF);
    chk("clr_tag", dep2, 0);
    chk("clr_count", ckpt_count, 0);
    step();

    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_in = ($urandom_range(0, 199) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      clr_in = ($urandom_range(0, 49) == 0);
      issue_ready = ($urandom_range(0, 9) < 6);
      issue_rd_id = 5'($urandom_range(0, 7));
      issue_rob_idx = RW'($urandom_range(1, 15));
      issue_ckpt = ($urandom_range(0, 9) < 3);
      ckpt_release = ($urandom_range(0, 3) == 0);
      if (m_q.size() > 0 && $urandom_range(0, 11) == 0) begin
        recover_valid = 1;
        recover_ckpt_id = CW'((m_head +
          $urandom_range(0, m_q.size() - 1)) % N);
      end
      rob_ready = ($urandom_range(0, 9) < 6);
      rob_reg = 5'($urandom_range(0, 7));
      rob_val = $urandom;
      rob_idx = ($urandom_range(0, 9) < 7)
                ? m_dep[rob_reg] : RW'($urandom_range(1, 15));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 1) == 0) ? rob_reg
                                       : 5'($urandom_range(0, 31));
      step();
    end

    idle(); step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
